apb_arbiter_2to1: RTL and testbench

- Two-requester APB arbiter that shares one downstream APB completer (the register bank `top`) between two upstream APB requesters.
- Each upstream side is an APB completer port; the downstream side is an APB requester port.
- Arbitration is round-robin, and transfers are serialised through a single sequencing FSM.
- A per-transfer timeout counter aborts downstream transfers that stall.

---
 rtl/apb_arbiter_2to1.sv | 214 +++++++++++++++++++++
 tb/tb_apb_arbiter_2to1.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter_2to1.sv
// Two-requester APB arbiter. Two upstream APB completer ports share one
// downstream APB requester port. Requests are granted round-robin and carried
// out one at a time. A per-transfer timeout aborts a downstream completer that
// never asserts pready.
module apb_arbiter_2to1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s0_apb_psel,
  input  logic                    s0_apb_penable,
  input  logic                    s0_apb_pwrite,
  input  logic [2:0]              s0_apb_pprot,
  input  logic [ADDR_WIDTH-1:0]   s0_apb_paddr,
  input  logic [DATA_WIDTH-1:0]   s0_apb_pwdata,
  input  logic [DATA_WIDTH/8-1:0] s0_apb_pstrb,
  output logic                    s0_apb_pready,
  output logic [DATA_WIDTH-1:0]   s0_apb_prdata,
  output logic                    s0_apb_pslverr,
  input  logic                    s1_apb_psel,
  input  logic                    s1_apb_penable,
  input  logic                    s1_apb_pwrite,
  input  logic [2:0]              s1_apb_pprot,
  input  logic [ADDR_WIDTH-1:0]   s1_apb_paddr,
  input  logic [DATA_WIDTH-1:0]   s1_apb_pwdata,
  input  logic [DATA_WIDTH/8-1:0] s1_apb_pstrb,
  output logic                    s1_apb_pready,
  output logic [DATA_WIDTH-1:0]   s1_apb_prdata,
  output logic                    s1_apb_pslverr,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [2:0]              m_apb_pprot,
  output logic [ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic [DATA_WIDTH-1:0]   m_apb_pwdata,
  output logic [DATA_WIDTH/8-1:0] m_apb_pstrb,
  input  logic                    m_apb_pready,
  input  logic [DATA_WIDTH-1:0]   m_apb_prdata,
  input  logic                    m_apb_pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // The counter only has to reach TIMEOUT-1.
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic                  rr_ptr_q, rr_ptr_d;   // 1: requester 1 wins a tie
  logic                  gnt_q, gnt_d;         // requester being serviced
  logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  m_psel_q, m_psel_d;
  logic                  m_penable_q, m_penable_d;
  logic                  m_pwrite_q, m_pwrite_d;
  logic [2:0]            m_pprot_q, m_pprot_d;
  logic [ADDR_WIDTH-1:0] m_paddr_q, m_paddr_d;
  logic [DATA_WIDTH-1:0] m_pwdata_q, m_pwdata_d;
  logic [STRB_W-1:0]     m_pstrb_q, m_pstrb_d;
  logic                  s0_pready_q, s0_pready_d;
  logic                  s1_pready_q, s1_pready_d;
  logic [DATA_WIDTH-1:0] s0_prdata_q, s0_prdata_d;
  logic [DATA_WIDTH-1:0] s1_prdata_q, s1_prdata_d;
  logic                  s0_pslverr_q, s0_pslverr_d;
  logic                  s1_pslverr_q, s1_pslverr_d;

  logic                  pick1;
  logic                  tmo_hit;

  // Upstream penable is deliberately not checked; a protocol-violating
  // requester is simply not detected.
  logic unused_penable;
  assign unused_penable = s0_apb_penable ^ s1_apb_penable;

  // Requester 1 wins when it is alone or when the pointer favours it.
  assign pick1   = s1_apb_psel & (~s0_apb_psel | rr_ptr_q);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and registered-output computation for the sequencing FSM.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    m_psel_d     = m_psel_q;
    m_penable_d  = m_penable_q;
    m_pwrite_d   = m_pwrite_q;
    m_pprot_d    = m_pprot_q;
    m_paddr_d    = m_paddr_q;
    m_pwdata_d   = m_pwdata_q;
    m_pstrb_d    = m_pstrb_q;
    s0_pready_d  = 1'b0;
    s1_pready_d  = 1'b0;
    s0_prdata_d  = s0_prdata_q;
    s1_prdata_d  = s1_prdata_q;
    s0_pslverr_d = s0_pslverr_q;
    s1_pslverr_d = s1_pslverr_q;

    case (state_q)
      IDLE: begin
        if (s0_apb_psel || s1_apb_psel) begin
          gnt_d       = pick1;
          m_pwrite_d  = pick1 ? s1_apb_pwrite : s0_apb_pwrite;
          m_pprot_d   = pick1 ? s1_apb_pprot  : s0_apb_pprot;
          m_paddr_d   = pick1 ? s1_apb_paddr  : s0_apb_paddr;
          m_pwdata_d  = pick1 ? s1_apb_pwdata : s0_apb_pwdata;
          m_pstrb_d   = pick1 ? s1_apb_pstrb  : s0_apb_pstrb;
          m_psel_d    = 1'b1;
          m_penable_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        m_penable_d = 1'b1;
        tmo_cnt_d   = '0;
        state_d     = ACCESS;
      end
      ACCESS: begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        if (m_apb_pready) begin
          m_psel_d    = 1'b0;
          m_penable_d = 1'b0;
          state_d     = DONE;
          if (gnt_q) begin
            s1_pready_d  = 1'b1;
            s1_pslverr_d = m_apb_pslverr;
            if (!m_pwrite_q) s1_prdata_d = m_apb_prdata;
          end else begin
            s0_pready_d  = 1'b1;
            s0_pslverr_d = m_apb_pslverr;
            if (!m_pwrite_q) s0_prdata_d = m_apb_prdata;
          end
        end else if (tmo_hit) begin
          // Stalled completer: abandon the transfer and report an error.
          m_psel_d    = 1'b0;
          m_penable_d = 1'b0;
          state_d     = DONE;
          if (gnt_q) begin
            s1_pready_d  = 1'b1;
            s1_pslverr_d = 1'b1;
            s1_prdata_d  = '0;
          end else begin
            s0_pready_d  = 1'b1;
            s0_pslverr_d = 1'b1;
            s0_prdata_d  = '0;
          end
        end
      end
      DONE: begin
        rr_ptr_d  = ~gnt_q;
        tmo_cnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      gnt_q        <= 1'b0;
      tmo_cnt_q    <= '0;
      m_psel_q     <= 1'b0;
      m_penable_q  <= 1'b0;
      m_pwrite_q   <= 1'b0;
      m_pprot_q    <= '0;
      m_paddr_q    <= '0;
      m_pwdata_q   <= '0;
      m_pstrb_q    <= '0;
      s0_pready_q  <= 1'b0;
      s1_pready_q  <= 1'b0;
      s0_prdata_q  <= '0;
      s1_prdata_q  <= '0;
      s0_pslverr_q <= 1'b0;
      s1_pslverr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      m_psel_q     <= m_psel_d;
      m_penable_q  <= m_penable_d;
      m_pwrite_q   <= m_pwrite_d;
      m_pprot_q    <= m_pprot_d;
      m_paddr_q    <= m_paddr_d;
      m_pwdata_q   <= m_pwdata_d;
      m_pstrb_q    <= m_pstrb_d;
      s0_pready_q  <= s0_pready_d;
      s1_pready_q  <= s1_pready_d;
      s0_prdata_q  <= s0_prdata_d;
      s1_prdata_q  <= s1_prdata_d;
      s0_pslverr_q <= s0_pslverr_d;
      s1_pslverr_q <= s1_pslverr_d;
    end
  end

  assign m_apb_psel     = m_psel_q;
  assign m_apb_penable  = m_penable_q;
  assign m_apb_pwrite   = m_pwrite_q;
  assign m_apb_pprot    = m_pprot_q;
  assign m_apb_paddr    = m_paddr_q;
  assign m_apb_pwdata   = m_pwdata_q;
  assign m_apb_pstrb    = m_pstrb_q;
  assign s0_apb_pready  = s0_pready_q;
  assign s1_apb_pready  = s1_pready_q;
  assign s0_apb_prdata  = s0_prdata_q;
  assign s1_apb_prdata  = s1_prdata_q;
  assign s0_apb_pslverr = s0_pslverr_q;
  assign s1_apb_pslverr = s1_pslverr_q;

endmodule

// File: tb/tb_apb_arbiter_2to1.sv
// Directed bench for apb_arbiter_2to1: two upstream requester drivers and a
// small downstream register-bank completer with programmable wait states,
// a never-ready mode and an error address.
module tb_apb_arbiter_2to1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [2:0]  pprot   [2];
  logic [6:0]  paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic        pready  [2];
  logic [31:0] prdata  [2];
  logic        pslverr [2];

  logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [2:0]  m_pprot;
  logic [6:0]  m_paddr;
  logic [31:0] m_pwdata, m_prdata;
  logic [3:0]  m_pstrb;

  // completer model state
  logic [31:0] regs [32];
  int          acc_cnt = 0;
  int          acc_total = 0;
  int          waits = 0;
  bit          hang = 1'b0;

  logic [31:0] rd0, rd1;
  logic        er0, er1;
  int          lat0, lat1, snap;

  apb_arbiter_2to1 dut (
    .clk(clk), .rst(rst),
    .s0_apb_psel(psel[0]), .s0_apb_penable(penable[0]), .s0_apb_pwrite(pwrite[0]),
    .s0_apb_pprot(pprot[0]), .s0_apb_paddr(paddr[0]), .s0_apb_pwdata(pwdata[0]),
    .s0_apb_pstrb(pstrb[0]), .s0_apb_pready(pready[0]), .s0_apb_prdata(prdata[0]),
    .s0_apb_pslverr(pslverr[0]),
    .s1_apb_psel(psel[1]), .s1_apb_penable(penable[1]), .s1_apb_pwrite(pwrite[1]),
    .s1_apb_pprot(pprot[1]), .s1_apb_paddr(paddr[1]), .s1_apb_pwdata(pwdata[1]),
    .s1_apb_pstrb(pstrb[1]), .s1_apb_pready(pready[1]), .s1_apb_prdata(prdata[1]),
    .s1_apb_pslverr(pslverr[1]),
    .m_apb_psel(m_psel), .m_apb_penable(m_penable), .m_apb_pwrite(m_pwrite),
    .m_apb_pprot(m_pprot), .m_apb_paddr(m_paddr), .m_apb_pwdata(m_pwdata),
    .m_apb_pstrb(m_pstrb), .m_apb_pready(m_pready), .m_apb_prdata(m_prdata),
    .m_apb_pslverr(m_pslverr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream completer: ready after 'waits' stalled ACCESS cycles, error at 0x7C.
  assign m_pready  = m_psel && m_penable && !hang && (acc_cnt >= waits);
  assign m_prdata  = regs[m_paddr[6:2]];
  assign m_pslverr = (m_paddr == 7'h7C);

  always @(posedge clk) begin
    if (m_psel && m_penable && !m_pready) acc_cnt <= acc_cnt + 1;
    else                                  acc_cnt <= 0;
    if (m_psel && m_penable) acc_total <= acc_total + 1;
    if (m_psel && m_penable && m_pready && m_pwrite)
      for (int b = 0; b < 4; b++)
        if (m_pstrb[b]) regs[m_paddr[6:2]][8*b +: 8] <= m_pwdata[8*b +: 8];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One upstream transfer; lat = cycles from setup to the pready cycle.
  task automatic apb_rw(input int idx, input logic wr, input logic [6:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    int  n;
    bit  got;
    @(posedge clk); #1;
    psel[idx] = 1'b1; penable[idx] = 1'b0; pwrite[idx] = wr;
    pprot[idx] = 3'(idx + 1); paddr[idx] = addr; pwdata[idx] = wdata; pstrb[idx] = 4'hF;
    n = cyc;
    @(posedge clk); #1;
    penable[idx] = 1'b1;
    got = 1'b0; lat = -1; rdata = '0; err = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (pready[idx]) begin
        got = 1'b1; lat = cyc - n; rdata = prdata[idx]; err = pslverr[idx];
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) check_val("bfm_no_pready", 32'd0, 32'd1);
    @(posedge clk); #1;
    psel[idx] = 1'b0; penable[idx] = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_mctl"}, {27'd0, m_psel, m_penable, m_pwrite, m_pprot != 3'd0, m_pstrb != 4'd0}, 32'd0);
    check_val({tag, "_maddr"}, {25'd0, m_paddr}, 32'd0);
    check_val({tag, "_mwdata"}, m_pwdata, 32'd0);
    check_val({tag, "_sctl"}, {28'd0, pready[0], pready[1], pslverr[0], pslverr[1]}, 32'd0);
    check_val({tag, "_srdata"}, prdata[0] | prdata[1], 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; pprot[i] = '0;
      paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0;
    end

    // reset state
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst = 1'b1;

    // single write from s0, cycle by cycle
    @(posedge clk); #1;
    psel[0] = 1'b1; pwrite[0] = 1'b1; pprot[0] = 3'b001; paddr[0] = 7'h04;
    pwdata[0] = 32'hDEADBEEF; pstrb[0] = 4'hF;
    check_val("wr_idle_psel", {31'd0, m_psel}, 32'd0);
    @(posedge clk); #1;
    check_val("wr_setup_ctl", {29'd0, m_psel, m_penable, m_pwrite}, 32'b101);
    check_val("wr_setup_addr", {25'd0, m_paddr}, 32'h04);
    check_val("wr_setup_wdata", m_pwdata, 32'hDEADBEEF);
    check_val("wr_setup_prot", {29'd0, m_pprot}, 32'd1);
    penable[0] = 1'b1;
    @(posedge clk); #1;
    check_val("wr_access_ctl", {30'd0, m_psel, m_penable}, 32'b11);
    @(posedge clk); #1;
    check_val("wr_done_ready", {29'd0, pready[0], pslverr[0], pready[1]}, 32'b100);
    check_val("wr_done_msel", {31'd0, m_psel}, 32'd0);
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    check_val("wr_ready_1cyc", {31'd0, pready[0]}, 32'd0);

    // read back through s1
    apb_rw(1, 1'b0, 7'h04, 32'd0, rd1, er1, lat1);
    check_val("rb_data", rd1, 32'hDEADBEEF);
    check_val("rb_lat", 32'(lat1), 32'd3);

    // preload registers for the arbitration rounds
    apb_rw(0, 1'b1, 7'h08, 32'hA5A50008, rd0, er0, lat0);
    apb_rw(0, 1'b1, 7'h0C, 32'h0000C00C, rd0, er0, lat0);

    // simultaneous requests after reset: s0 first
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    fork
      apb_rw(0, 1'b0, 7'h08, 32'd0, rd0, er0, lat0);
      apb_rw(1, 1'b0, 7'h0C, 32'd0, rd1, er1, lat1);
    join
    check_val("rrA_s0_lat", 32'(lat0), 32'd3);
    check_val("rrA_s1_lat", 32'(lat1), 32'd7);
    check_val("rrA_s0_data", rd0, 32'hA5A50008);
    check_val("rrA_s1_data", rd1, 32'h0000C00C);

    // one s0 transfer moves the pointer to s1, so s1 wins the next tie
    apb_rw(0, 1'b0, 7'h04, 32'd0, rd0, er0, lat0);
    fork
      apb_rw(0, 1'b0, 7'h08, 32'd0, rd0, er0, lat0);
      apb_rw(1, 1'b0, 7'h0C, 32'd0, rd1, er1, lat1);
    join
    check_val("rrB_s1_lat", 32'(lat1), 32'd3);
    check_val("rrB_s0_lat", 32'(lat0), 32'd7);
    check_val("rrB_s1_data", rd1, 32'h0000C00C);

    // wait states: three stalled ACCESS cycles
    apb_rw(0, 1'b1, 7'h14, 32'h12345678, rd0, er0, lat0);
    waits = 3;
    fork
      apb_rw(0, 1'b0, 7'h14, 32'd0, rd0, er0, lat0);
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (m_psel) check_val("ws_paddr_stable", {25'd0, m_paddr}, 32'h14);
      end
    join
    waits = 0;
    check_val("ws_lat", 32'(lat0), 32'd6);
    check_val("ws_data", rd0, 32'h12345678);
    check_val("ws_err", {31'd0, er0}, 32'd0);

    // timeout: completer never responds
    hang = 1'b1;
    snap = acc_total;
    apb_rw(1, 1'b0, 7'h04, 32'd0, rd1, er1, lat1);
    hang = 1'b0;
    check_val("to_access_cycles", 32'(acc_total - snap), 32'd16);
    check_val("to_lat", 32'(lat1), 32'd18);
    check_val("to_err", {31'd0, er1}, 32'd1);
    check_val("to_data", rd1, 32'd0);
    apb_rw(0, 1'b0, 7'h04, 32'd0, rd0, er0, lat0);
    check_val("after_to_data", rd0, 32'hDEADBEEF);
    check_val("after_to_err_lat", {er0 ? 32'd1 : 32'd0} + 32'(lat0), 32'd3);

    // completer error at 0x7C
    apb_rw(0, 1'b0, 7'h7C, 32'd0, rd0, er0, lat0);
    check_val("slverr_err", {31'd0, er0}, 32'd1);
    check_val("slverr_lat", 32'(lat0), 32'd3);

    // reset during ACCESS
    hang = 1'b1;
    @(posedge clk); #1;
    psel[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 7'h04; penable[0] = 1'b0;
    @(posedge clk); #1 penable[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("mid_access", {30'd0, m_psel, m_penable}, 32'b11);
    #2 rst = 1'b0;
    #1 check_outputs_zero("mid_reset");
    psel[0] = 1'b0; penable[0] = 1'b0; hang = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check_val("post_rst_quiet", {30'd0, pready[0] | pready[1], m_psel}, 32'd0);
    end
    fork
      apb_rw(0, 1'b0, 7'h08, 32'd0, rd0, er0, lat0);
      apb_rw(1, 1'b0, 7'h0C, 32'd0, rd1, er1, lat1);
    join
    check_val("rrC_s0_lat", 32'(lat0), 32'd3);
    check_val("rrC_s1_lat", 32'(lat1), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
